// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers for the write and read sides: pointer-width default,
// gray/binary conversion and the full-compare on gray pointers.
package fifo_pkg;

    localparam int PTR_WIDTH_DEFAULT = 4;
    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    localparam int MAX_PTR_BITS = 32;

    function automatic logic [MAX_PTR_BITS-1:0] bin2gray(input logic [MAX_PTR_BITS-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_PTR_BITS-1:0] gray2bin(input logic [MAX_PTR_BITS-1:0] gray);
        logic [MAX_PTR_BITS-1:0] bin;
        bin[MAX_PTR_BITS-1] = gray[MAX_PTR_BITS-1];
        for (int i = MAX_PTR_BITS - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Full when the write gray pointer equals the read gray pointer with its two
    // top bits inverted, i.e. the writer is exactly one lap ahead.
    function automatic logic full_match(input logic [MAX_PTR_BITS-1:0] wr_gray,
                                        input logic [MAX_PTR_BITS-1:0] rd_gray,
                                        input int width);
        logic [MAX_PTR_BITS-1:0] mask;
        mask = MAX_PTR_BITS'(3) << (width - 2);
        return wr_gray == (rd_gray ^ mask);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage flop synchronizer for a gray-coded bus entering the clk domain.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_reg;
    logic [WIDTH-1:0] stage2_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            stage1_reg <= '0;
            stage2_reg <= '0;
        end else begin
            stage1_reg <= d;
            stage2_reg <= stage1_reg;
        end
    end

    assign q = stage2_reg;

endmodule

// File: rtl/write_handler.sv
// Async FIFO write-side pointer/flag logic. Optional almost_full/wr_level outputs
// are built when WRITE_HANDLER_ALMOST_FULL_EN is defined.
module write_handler
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEFAULT,
    parameter int AF_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [PTR_WIDTH:0] rd_ptr,
    output logic               wr_accept,
    output logic               full,
    output logic               overflow,
    output logic [PTR_WIDTH:0] bin_wr_ptr,
    output logic [PTR_WIDTH:0] gray_wr_ptr
`ifdef WRITE_HANDLER_ALMOST_FULL_EN
    ,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_level
`endif
);

    localparam int PW1   = PTR_WIDTH + 1;
    localparam int DEPTH = 1 << PTR_WIDTH;

    logic [PW1-1:0] rd_ptr_sync;
    logic [PW1-1:0] bin_reg, bin_next;
    logic [PW1-1:0] gray_reg, gray_next;
    logic           full_reg, full_next;
    logic           overflow_reg, overflow_next;

    sync_2ff #(.WIDTH(PW1)) u_rd_sync (
        .clk  (clk),
        .srst (rst),
        .d    (rd_ptr),
        .q    (rd_ptr_sync)
    );

    // The flag is computed from the post-push pointer so it rises with zero lag.
    always_comb begin
        wr_accept     = wr_en & ~full_reg & ~rst;
        bin_next      = bin_reg + PW1'(wr_accept);
        gray_next     = PW1'(bin2gray(MAX_PTR_BITS'(bin_next)));
        full_next     = full_match(MAX_PTR_BITS'(gray_next), MAX_PTR_BITS'(rd_ptr_sync), PW1);
        overflow_next = overflow_reg | (wr_en & full_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg      <= '0;
            gray_reg     <= '0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            bin_reg      <= bin_next;
            gray_reg     <= gray_next;
            full_reg     <= full_next;
            overflow_reg <= overflow_next;
        end
    end

    assign full        = full_reg;
    assign overflow    = overflow_reg;
    assign bin_wr_ptr  = bin_reg;
    assign gray_wr_ptr = gray_reg;

`ifdef WRITE_HANDLER_ALMOST_FULL_EN
    logic [PW1-1:0] rd_bin;
    logic [PW1-1:0] level_reg, level_next;
    logic           af_reg, af_next;

    always_comb begin
        rd_bin     = PW1'(gray2bin(MAX_PTR_BITS'(rd_ptr_sync)));
        level_next = bin_next - rd_bin;
        af_next    = int'(level_next) >= (DEPTH - AF_MARGIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= '0;
            af_reg    <= 1'b0;
        end else begin
            level_reg <= level_next;
            af_reg    <= af_next;
        end
    end

    assign almost_full = af_reg;
    assign wr_level    = level_reg;
`else
    // The margin only matters for the level outputs; nothing to build here.
    if (AF_MARGIN > DEPTH) begin : g_margin_exceeds_depth
    end
`endif

endmodule

// File: doc/write_handler.md
WRITE_HANDLER -- requirements
Module: write_handler

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 4, address width; FIFO depth = 2**PTR_WIDTH; pointers PTR_WIDTH+1 bits.
REQ-002 SHALL have parameter AF_MARGIN, default 2, free-slot threshold for almost_full (used only under macro).
REQ-003 SHALL have port clk  input  1  write-domain clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  push request from producer.
REQ-006 SHALL have port rd_ptr  input  PTR_WIDTH+1  gray-coded read pointer from read domain, asynchronous to clk.
REQ-007 SHALL have port wr_accept  output  1  memory write strobe, = wr_en & ~full (combinational).
REQ-008 SHALL have port full  output  1  registered full flag.
REQ-009 SHALL have port overflow  output  1  sticky flag: push attempted while full.
REQ-010 SHALL have port bin_wr_ptr  output  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits = memory address.
REQ-011 SHALL have port gray_wr_ptr  output  PTR_WIDTH+1  registered gray write pointer for read-domain synchronizer.
REQ-012 SHALL have ports almost_full (1) and wr_level (PTR_WIDTH+1) as outputs only when the macro is defined.

Function
REQ-013 SHALL pass rd_ptr through a 2-stage flop synchronizer (rd_ptr_sync); full uses only the stage-2 value.
REQ-014 SHALL increment bin_wr_ptr by 1 on each clk edge with wr_accept=1, modulo 2**(PTR_WIDTH+1); unchanged otherwise.
REQ-015 SHALL register gray_wr_ptr = bin_next ^ (bin_next >> 1) on the same edge as bin_wr_ptr; it changes by exactly one bit per push.
REQ-016 SHALL register full <= (gray of bin_next == {~rd_ptr_sync[MSB:MSB-1], rd_ptr_sync[MSB-2:0]}).
REQ-017 SHALL assert full in the cycle right after the push that fills the last slot (zero-lag on assertion).
REQ-018 SHALL deassert full no earlier than 3 clk edges after a rd_ptr change (2 sync + 1 flag register); pessimistic, never optimistic.
REQ-019 SHALL ignore wr_en while full: pointer holds, wr_accept=0, overflow set to 1 on that edge and held until reset.
REQ-020 SHALL, on simultaneous last-slot push and stale sync pointer, keep full=1 until the synchronized pointer shows space.
REQ-021 SHALL wrap pointer MSB on each pass through the depth; full/empty distinction relies on MSB, never on address bits alone.

Reset
REQ-022 SHALL, with rst=1 at a clk edge, clear bin_wr_ptr, gray_wr_ptr, both synchronizer stages, full, overflow, almost_full and wr_level to 0.
REQ-023 SHALL give rst priority over wr_en; reset mid-stream discards pointer state, wr_accept=0 during rst.
REQ-024 SHALL accept a push on the first edge after rst falls.

Configuration
REQ-025 SHALL support macro WRITE_HANDLER_ALMOST_FULL_EN.
REQ-026 With macro: convert rd_ptr_sync gray->binary, register wr_level <= bin_next - rd_bin (mod 2**(PTR_WIDTH+1)), register almost_full <= (wr_level_next >= DEPTH - AF_MARGIN).
REQ-027 Without macro: no almost_full/wr_level ports, no gray->binary logic; all other behaviour identical.

Structure
REQ-028 SHALL import a shared package fifo_pkg holding default PTR_WIDTH, the bin2gray and gray2bin functions, and the full-compare helper, shared with the read side.
REQ-029 SHALL instantiate one sub-module sync_2ff (parameterized width, synchronous active-high reset) for the rd_ptr crossing.

Verification (PTR_WIDTH=4, depth 16, AF_MARGIN=2, rd_ptr held 0)
REQ-030 Reset: rst=1 two cycles -> all outputs 0; first wr_en after release -> bin_wr_ptr=1, gray_wr_ptr=5'b00001.
REQ-031 Fill: 16 consecutive pushes -> full=1 the cycle after push 16, bin_wr_ptr=5'b10000, gray_wr_ptr=5'b11000.
REQ-032 Overflow: wr_en=1 while full -> wr_accept=0, pointer stays 16, overflow=1 and remains 1 after wr_en drops.
REQ-033 Drain: with full=1, drive rd_ptr=gray(1)=5'b00001 -> full drops exactly 3 edges later; one push -> full=1 again, bin_wr_ptr=17.
REQ-034 Wrap: push 32 with matching rd_ptr advances -> bin_wr_ptr returns to 0, full never falsely asserted; gray single-bit change every push (checked by assertion).
REQ-035 Macro on: after 14 pushes -> wr_level=14, almost_full=1; at 13 -> almost_full=0; mid-fill rst -> wr_level=0, almost_full=0.
